// File: rtl/paridade_pkg.sv
// Shared types for the serial even-parity generator/checker pair.
package paridade_pkg;

    typedef enum logic [0:0] {
        PAR   = 1'b0,
        IMPAR = 1'b1
    } parity_state_t;

    typedef enum logic {
        RECV  = 1'b0,
        CHECK = 1'b1
    } frame_state_t;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/even_parity_tracker.sv
// Running-parity toggle FSM (PAR/IMPAR), shared by the serial parity generator and checker.
module even_parity_tracker
    import paridade_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic in_bit,
    output logic odd
);

    parity_state_t parState_q;

    // When clr and en are both high, clr wins: the bit that ends a frame
    // must not leak its parity into the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parState_q <= PAR;
        end else if (en) begin
            if (clr) begin
                parState_q <= PAR;
            end else if (in_bit) begin
                parState_q <= (parState_q == PAR) ? IMPAR : PAR;
            end
        end
    end

    assign odd = (parState_q == IMPAR);

endmodule

// File: rtl/even_parity_frame_checker.sv
// Serial even-parity frame checker: DATA_W data bits LSB first, then one parity bit.
// Optional macro PARITY_ERR_COUNT_EN adds a saturating 8-bit parity error counter.
module even_parity_frame_checker
    import paridade_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              parity_err,
    output logic              par_state
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    frame_state_t      state_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              runOdd;
    logic              parityClr;
    logic              frameErr_d;

    assign parityClr  = in_valid && (state_q == CHECK);
    assign frameErr_d = runOdd ^ in_bit;

    even_parity_tracker u_tracker (
        .clk    (clk),
        .reset  (reset),
        .en     (in_valid),
        .clr    (parityClr),
        .in_bit (in_bit),
        .odd    (runOdd)
    );

    // Bits enter at the MSB side so the first-received bit ends up in bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RECV;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    RECV: begin
                        shift_q <= {in_bit, shift_q[DATA_W-1:1]};
                        if (bitCnt_q == LAST_CNT) begin
                            bitCnt_q <= '0;
                            state_q  <= CHECK;
                        end else begin
                            bitCnt_q <= bitCnt_q + CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        data_out    <= shift_q;
                        parity_err  <= frameErr_d;
                        frame_valid <= 1'b1;
                        state_q     <= RECV;
                    end
                    default: state_q <= RECV;
                endcase
            end
        end
    end

    assign par_state = runOdd;

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] errCount_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCount_q <= '0;
        end else if (parityClr && frameErr_d && (errCount_q != 8'hFF)) begin
            errCount_q <= errCount_q + 8'd1;
        end
    end

    assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_even_parity_frame_checker.sv
// Bench for even_parity_frame_checker: directed and random frames against a bit-queue reference model.
module tb_even_parity_frame_checker;

    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_bit;
    logic [DATA_W-1:0] data_out;
    logic              frame_valid;
    logic              parity_err;
    logic              par_state;
`ifdef PARITY_ERR_COUNT_EN
    logic [7:0]        err_count;
`endif

    even_parity_frame_checker #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .parity_err  (parity_err),
        .par_state   (par_state)
`ifdef PARITY_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the bits of the frame in progress, plus the last completed result.
    bit             frameQ[$];
    logic [DATA_W-1:0] expData = '0;
    logic           expErr = 1'b0;
    logic           expFv = 1'b0;
    int             expErrCnt = 0;

    function automatic logic queueOdd();
        int ones = 0;
        foreach (frameQ[i]) ones += int'(frameQ[i]);
        return logic'(ones % 2);
    endfunction

    task automatic modelSample(input logic b);
        if (frameQ.size() == DATA_W) begin
            logic [DATA_W-1:0] word = '0;
            int ones = int'(b);
            foreach (frameQ[i]) begin
                if (frameQ[i]) word = word | (DATA_W'(1) << i);
                ones += int'(frameQ[i]);
            end
            expData = word;
            expErr  = logic'(ones % 2);
            expFv   = 1'b1;
            if (expErr && expErrCnt < 255) expErrCnt++;
            frameQ.delete();
        end else begin
            frameQ.push_back(b);
            expFv = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/fv"},   32'(frame_valid), 32'(expFv));
        checkOutput({tag, "/data"}, 32'(data_out),    32'(expData));
        checkOutput({tag, "/err"},  32'(parity_err),  32'(expErr));
        checkOutput({tag, "/par"},  32'(par_state),   32'(queueOdd()));
`ifdef PARITY_ERR_COUNT_EN
        checkOutput({tag, "/cnt"},  32'(err_count),   32'(expErrCnt));
`endif
    endtask

    task automatic applyStimulus(input logic b, input string tag);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        modelSample(b);
        checkAll(tag);
    endtask

    task automatic idle(input int n, input string tag);
        in_valid = 1'b0;
        repeat (n) begin
            in_bit = 1'($urandom);
            @(posedge clk);
            #1;
            expFv = 1'b0;
            checkAll(tag);
        end
    endtask

    task automatic sendFrame(input logic [DATA_W-1:0] data, input logic p,
                             input int minGap, input int maxGap, input string tag);
        for (int i = 0; i < DATA_W; i++) begin
            applyStimulus(data[i], tag);
            if (maxGap > 0) idle($urandom_range(maxGap, minGap), tag);
        end
        applyStimulus(p, tag);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        frameQ.delete();
        expData = '0;
        expErr = 1'b0;
        expFv = 1'b0;
        expErrCnt = 0;
    endtask

    initial begin
        int t1;
        int t2;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        #2;
        checkAll("reset");
        @(negedge clk);
        reset = 1'b0;
        idle(2, "post_reset");

        sendFrame(8'hA5, 1'b0, 0, 0, "a5");
        checkOutput("a5_fv", 32'(frame_valid), 32'h1);
        checkOutput("a5_data", 32'(data_out), 32'hA5);
        checkOutput("a5_err", 32'(parity_err), 32'h0);
        idle(1, "a5_after");

        sendFrame(8'h01, 1'b0, 0, 0, "x01_p0");
        checkOutput("x01_p0_err", 32'(parity_err), 32'h1);
        checkOutput("x01_p0_data", 32'(data_out), 32'h01);
        sendFrame(8'h01, 1'b1, 0, 0, "x01_p1");
        checkOutput("x01_p1_err", 32'(parity_err), 32'h0);
        idle(2, "x01_after");

        sendFrame(8'h3C, 1'b0, 1, 3, "gap3c");
        checkOutput("gap3c_data", 32'(data_out), 32'h3C);
        checkOutput("gap3c_err", 32'(parity_err), 32'h0);
        idle(3, "gap3c_after");

        applyStimulus(1'b1, "partial");
        applyStimulus(1'b0, "partial");
        applyStimulus(1'b1, "partial");
        #3;
        applyReset();
        #1;
        checkAll("mid_reset");
        checkOutput("mid_reset_data", 32'(data_out), 32'h0);
        @(posedge clk);
        #1;
        checkAll("hold_reset");
        @(negedge clk);
        reset = 1'b0;
        sendFrame(8'hFF, 1'b0, 0, 0, "ff");
        checkOutput("ff_data", 32'(data_out), 32'hFF);
        checkOutput("ff_err", 32'(parity_err), 32'h0);

        sendFrame(8'h80, 1'b1, 0, 0, "b2b_80");
        t1 = cycle;
        checkOutput("b2b_80_data", 32'(data_out), 32'h80);
        checkOutput("b2b_80_err", 32'(parity_err), 32'h0);
        sendFrame(8'h7F, 1'b1, 0, 0, "b2b_7f");
        t2 = cycle;
        checkOutput("b2b_7f_data", 32'(data_out), 32'h7F);
        checkOutput("b2b_7f_err", 32'(parity_err), 32'h0);
        checkOutput("b2b_spacing", 32'(t2 - t1), 32'd9);
        idle(2, "b2b_after");

        for (int f = 0; f < 24; f++) begin
            sendFrame(DATA_W'($urandom), 1'($urandom), 0, 2, "random");
            if (($urandom % 3) == 0) idle($urandom_range(2, 0), "random_idle");
        end

`ifdef PARITY_ERR_COUNT_EN
        for (int f = 0; f < 257; f++) begin
            logic [DATA_W-1:0] d = DATA_W'($urandom);
            sendFrame(d, ~(^d), 0, 0, "bad");
        end
        checkOutput("cnt_sat", 32'(err_count), 32'd255);
        sendFrame(8'h5A, 1'b0, 0, 0, "good_after_sat");
        checkOutput("cnt_hold", 32'(err_count), 32'd255);
        applyReset();
        #1;
        checkOutput("cnt_reset", 32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(1, "cnt_after_reset");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/even_parity_frame_checker.md
Name: even_parity_frame_checker

Overview:
- Receive-side counterpart of the team's serial even-parity generator.
- Deserializes frames of DATA_W data bits (LSB first), each followed by one parity bit.
- Checks that the total count of ones in data plus parity is even.
- Presents the recovered word with a one-cycle completion strobe and an error flag.
- Sits at the serial link input, ahead of word-level consumers.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  qualifies in_bit for the current cycle; no sampling when low.
- in_bit  input  1  serial bit: data bits LSB first, then the parity bit.
- data_out  output  DATA_W  last completed frame's data word.
- frame_valid  output  1  one-cycle pulse on frame completion.
- parity_err  output  1  parity result of last completed frame (1 = odd total).
- par_state  output  1  live running parity of the current frame (1 = odd so far).

Behaviour:
- Reset (asynchronous, active-high): the following take effect immediately and hold while reset is high.
  - state = RECV, bit_cnt = 0, running parity = PAR, shift register = 0.
  - data_out = 0, frame_valid = 0, parity_err = 0, par_state = 0.
- Only cycles with in_valid = 1 advance anything. With in_valid = 0, all state holds and frame_valid = 0.
- Running parity FSM (states PAR/IMPAR):
  - A sampled in_bit = 1 toggles the state; in_bit = 0 keeps it.
  - par_state = (state == IMPAR), combinational from the register.
- Frame FSM:
  - RECV: each sampled bit shifts in at the MSB side, so after DATA_W bits bit 0 holds the first-received bit. bit_cnt increments.
    - When the sampled bit is the DATA_W-th (bit_cnt == DATA_W-1), go to CHECK and set bit_cnt = 0.
  - CHECK: the next sampled bit is the parity bit. On that cycle:
    - data_out <= shift register.
    - parity_err <= running parity XOR in_bit.
    - frame_valid <= 1 for exactly one cycle.
    - Running parity returns to PAR and the FSM returns to RECV.
- Latency:
  - frame_valid rises on the clock edge that samples the parity bit, i.e. visible the cycle after that bit is presented.
  - data_out and parity_err update on that same edge and hold until the next frame completes.
- Back-to-back frames: a first data bit presented in the cycle right after the parity bit is accepted. No idle cycle is required.
- bit_cnt width is $clog2(DATA_W); it never exceeds DATA_W-1.
- Reset mid-frame discards the partial frame; the next sampled bit is treated as data bit 0.
- There is no framing or start-bit detection: alignment comes from reset only.

Optional Feature:
- Macro PARITY_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [7:0].
  - err_count increments on each frame_valid with parity_err = 1, saturating at 255.
  - Cleared by reset.
- Undefined: no err_count port and no counter logic. All other behaviour is identical.

Decomposition:
- Package paridade_pkg holds:
  - enum parity_state_t {PAR, IMPAR} (logic [0:0]).
  - enum frame_state_t {RECV, CHECK}.
  - localparam DEFAULT_DATA_W = 8.
- One sub-module, even_parity_tracker:
  - Ports: clk, reset, en, clr, in_bit, odd.
  - Wraps the PAR/IMPAR toggle FSM.
  - The same block is reusable by the transmit-side generator.

Test Plan:
- After reset, send 0xA5 LSB first (1,0,1,0,0,1,0,1) then parity 0, in_valid continuous -> one frame_valid pulse, data_out = 0xA5, parity_err = 0.
- Send 0x01 with parity 0 -> data_out = 0x01, parity_err = 1. Then send 0x01 with parity 1 -> parity_err = 0.
- Send 0x3C with random in_valid gaps (1-3 idle cycles between bits) -> same result as gap-free: data_out = 0x3C, parity_err = 0, exactly one frame_valid pulse.
- Send 3 bits of a frame, assert reset asynchronously mid-cycle, release, then send 0xFF with parity 0 -> outputs 0 during reset, then data_out = 0xFF, parity_err = 0.
- Send back-to-back frames 0x80/p1 then 0x7F/p1 with no idle cycles -> frame_valid pulses 9 cycles apart. Frame 1 gives data_out = 0x80, parity_err = 0; frame 2 gives data_out = 0x7F, parity_err = 0.
- With PARITY_ERR_COUNT_EN, send 257 bad frames -> err_count saturates at 255. Then a good frame -> err_count stays 255. Reset -> err_count = 0.
